// File: rtl/mdu_unit.sv
// mdu_unit
// ----------------------------------------------------------------------------
// RISC-V M-extension multiply/divide execution unit. Sits next to the integer
// ALU on the reservation-station issue path and reports results on the same
// ROB completion format (one-cycle finish pulse, ROB id, XLEN-bit result).
//
// The multiplier is a fully pipelined datapath of MUL_LAT stages feeding the
// shared output register. The divider is an iterative restoring divider that
// takes one quotient bit per cycle. Its three-state FSM (IDLE/BUSY/DONE)
// back-pressures div issue through div_ready.
//
// Parameters
//   XLEN      operand/result width (even, >= 8)
//   ROB_ID_W  ROB id width
//   MUL_LAT   multiplier latency in cycles (>= 1)
//
// Ports
//   clk_in       system clock
//   rst_n_in     asynchronous active-low reset
//   rdy_in       global ready; low freezes every register
//   mdu_input    issue strobe
//   op           funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   r1_val       rs1 operand
//   r2_val       rs2 operand
//   inst_rob_id  ROB id of the issued instruction
//   mul_ready    a multiply issue is accepted this cycle
//   div_ready    a divide issue is accepted this cycle
//   mdu_fi       registered result-valid pulse
//   cur_rob_id   ROB id of the result (0 when mdu_fi=0)
//   res          result value
//   rob_clear    flush (effective only when rdy_in=1)
// ----------------------------------------------------------------------------

`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module mdu_unit #(
    parameter int XLEN     = 32,
    parameter int ROB_ID_W = `ROB_SIZE_BIT,
    parameter int MUL_LAT  = 2
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                mdu_input,
    input  logic [2:0]          op,
    input  logic [XLEN-1:0]     r1_val,
    input  logic [XLEN-1:0]     r2_val,
    input  logic [ROB_ID_W-1:0] inst_rob_id,
    output logic                mul_ready,
    output logic                div_ready,
    output logic                mdu_fi,
    output logic [ROB_ID_W-1:0] cur_rob_id,
    output logic [XLEN-1:0]     res,
    input  logic                rob_clear
);

    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                mul_valid [MUL_LAT];
    logic [ROB_ID_W-1:0] mul_id    [MUL_LAT];
    logic [1:0]          mul_op    [MUL_LAT];
    logic [2*XLEN-1:0]   mul_prod  [MUL_LAT];

    div_state_t          div_state;
    logic [CNT_W-1:0]    div_cnt;
    logic [XLEN-1:0]     div_quo;
    logic [XLEN-1:0]     div_rem;
    logic [XLEN-1:0]     div_dsr;
    logic                div_neg_q;
    logic                div_neg_r;
    logic                div_is_rem;
    logic [ROB_ID_W-1:0] div_id;
    logic [XLEN-1:0]     div_result;

    // ------------------------------------------------------------------------
    // Issue acceptance and arbitration
    // ------------------------------------------------------------------------
    logic issue_ok;
    logic mul_issue;
    logic div_issue;
    logic mul_last_valid;
    logic div_emit;

    // Holding mul_ready low while a div result waits lets the multiplier
    // pipeline drain, so the divider is guaranteed an output slot.
    assign mul_ready      = (div_state != DIV_DONE);
    assign div_ready      = (div_state == DIV_IDLE);
    assign issue_ok       = rdy_in && !rob_clear && mdu_input;
    assign mul_issue      = issue_ok && !op[2] && mul_ready;
    assign div_issue      = issue_ok &&  op[2] && div_ready;
    assign mul_last_valid = mul_valid[MUL_LAT-1];
    assign div_emit       = (div_state == DIV_DONE) && !mul_last_valid;

    // ------------------------------------------------------------------------
    // Multiplier operand extension. Both operands are widened to 2*XLEN with
    // sign or zero fill; the low 2*XLEN bits of that product are the exact
    // signed/unsigned product for every mul variant.
    // ------------------------------------------------------------------------
    logic              mul_a_sign;
    logic              mul_b_sign;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_full;

    always_comb begin
        mul_a_sign = (op[1:0] != 2'b11) && r1_val[XLEN-1];
        mul_b_sign = !op[1] && r2_val[XLEN-1];
        mul_a      = {{XLEN{mul_a_sign}}, r1_val};
        mul_b      = {{XLEN{mul_b_sign}}, r2_val};
        mul_full   = mul_a * mul_b;
    end

    // ------------------------------------------------------------------------
    // Multiplier pipeline: each stage carries valid, ROB id, op and product.
    // The high/low half is selected when the last stage is written out.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                mul_valid[i] <= 1'b0;
                mul_id[i]    <= '0;
                mul_op[i]    <= '0;
                mul_prod[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (rob_clear) begin
                for (int i = 0; i < MUL_LAT; i++) begin
                    mul_valid[i] <= 1'b0;
                end
            end else begin
                mul_valid[0] <= mul_issue;
                mul_id[0]    <= inst_rob_id;
                mul_op[0]    <= op[1:0];
                mul_prod[0]  <= mul_full;
                for (int i = 1; i < MUL_LAT; i++) begin
                    mul_valid[i] <= mul_valid[i-1];
                    mul_id[i]    <= mul_id[i-1];
                    mul_op[i]    <= mul_op[i-1];
                    mul_prod[i]  <= mul_prod[i-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Divider issue-side decode: absolute values, sign flags and the two
    // special cases that skip the iterative loop.
    // ------------------------------------------------------------------------
    logic            dvd_neg;
    logic            dsr_neg;
    logic [XLEN-1:0] dvd_abs;
    logic [XLEN-1:0] dsr_abs;
    logic            div_by_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        dvd_neg     = !op[0] && r1_val[XLEN-1];
        dsr_neg     = !op[0] && r2_val[XLEN-1];
        dvd_abs     = dvd_neg ? -r1_val : r1_val;
        dsr_abs     = dsr_neg ? -r2_val : r2_val;
        div_by_zero = (r2_val == '0);
        div_ovf     = !op[0] && (r1_val == {1'b1, {(XLEN-1){1'b0}}})
                      && (r2_val == '1);
        if (div_by_zero) begin
            special_res = op[1] ? r1_val : '1;
        end else begin
            special_res = op[1] ? '0 : r1_val;
        end
    end

    // ------------------------------------------------------------------------
    // One restoring-division step. The dividend is shifted out of div_quo
    // while quotient bits are shifted in. The partial remainder always stays
    // below the divisor, so the XLEN-bit difference is exact when taken.
    // ------------------------------------------------------------------------
    logic [XLEN:0]   rem_sh;
    logic            step_ge;
    logic [XLEN-1:0] rem_diff;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    always_comb begin
        rem_sh   = {div_rem, div_quo[XLEN-1]};
        step_ge  = (rem_sh >= {1'b0, div_dsr});
        rem_diff = rem_sh[XLEN-1:0] - div_dsr;
        rem_next = step_ge ? rem_diff : rem_sh[XLEN-1:0];
        quo_next = {div_quo[XLEN-2:0], step_ge};
        quo_fix  = div_neg_q ? -quo_next : quo_next;
        rem_fix  = div_neg_r ? -rem_next : rem_next;
    end

    // ------------------------------------------------------------------------
    // Divider FSM. The counter is loaded with XLEN, and the final step is
    // taken in the same cycle as the sign fixup, so BUSY lasts exactly XLEN
    // cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_state  <= DIV_IDLE;
            div_cnt    <= '0;
            div_quo    <= '0;
            div_rem    <= '0;
            div_dsr    <= '0;
            div_neg_q  <= 1'b0;
            div_neg_r  <= 1'b0;
            div_is_rem <= 1'b0;
            div_id     <= '0;
            div_result <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                div_state <= DIV_IDLE;
                div_cnt   <= '0;
            end else begin
                case (div_state)
                    DIV_IDLE: begin
                        if (div_issue) begin
                            div_id <= inst_rob_id;
                            if (div_by_zero || div_ovf) begin
                                div_result <= special_res;
                                div_state  <= DIV_DONE;
                            end else begin
                                div_quo    <= dvd_abs;
                                div_rem    <= '0;
                                div_dsr    <= dsr_abs;
                                div_neg_q  <= dvd_neg ^ dsr_neg;
                                div_neg_r  <= dvd_neg;
                                div_is_rem <= op[1];
                                div_cnt    <= CNT_W'(XLEN);
                                div_state  <= DIV_BUSY;
                            end
                        end
                    end
                    DIV_BUSY: begin
                        div_quo <= quo_next;
                        div_rem <= rem_next;
                        div_cnt <= div_cnt - 1'b1;
                        if (div_cnt == CNT_W'(1)) begin
                            div_result <= div_is_rem ? rem_fix : quo_fix;
                            div_state  <= DIV_DONE;
                        end
                    end
                    DIV_DONE: begin
                        if (div_emit) begin
                            div_state <= DIV_IDLE;
                        end
                    end
                    default: begin
                        div_state <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Completion register. The multiplier's last stage always wins; a waiting
    // div result goes out only in a cycle with no multiplier result.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mdu_fi     <= 1'b0;
            cur_rob_id <= '0;
            res        <= '0;
        end else if (rdy_in) begin
            if (rob_clear) begin
                mdu_fi     <= 1'b0;
                cur_rob_id <= '0;
                res        <= '0;
            end else if (mul_last_valid) begin
                mdu_fi     <= 1'b1;
                cur_rob_id <= mul_id[MUL_LAT-1];
                res        <= (mul_op[MUL_LAT-1] == 2'b00)
                              ? mul_prod[MUL_LAT-1][XLEN-1:0]
                              : mul_prod[MUL_LAT-1][2*XLEN-1:XLEN];
            end else if (div_state == DIV_DONE) begin
                mdu_fi     <= 1'b1;
                cur_rob_id <= div_id;
                res        <= div_result;
            end else begin
                mdu_fi     <= 1'b0;
                cur_rob_id <= '0;
                res        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit
// ----------------------------------------------------------------------------
// Scoreboard bench for mdu_unit (XLEN=32, MUL_LAT=2, ROB_ID_W=4). Each issue
// pushes its expected ROB id, value and arrival edge into a queue kept in
// arrival order; a negedge monitor pops and compares every result pulse.
// ----------------------------------------------------------------------------

module tb_mdu_unit;

    localparam int XLEN     = 32;
    localparam int ROB_ID_W = 4;
    localparam int MUL_LAT  = 2;

    logic                clk_in = 1'b0;
    logic                rst_n_in;
    logic                rdy_in;
    logic                mdu_input;
    logic [2:0]          op;
    logic [XLEN-1:0]     r1_val;
    logic [XLEN-1:0]     r2_val;
    logic [ROB_ID_W-1:0] inst_rob_id;
    logic                mul_ready;
    logic                div_ready;
    logic                mdu_fi;
    logic [ROB_ID_W-1:0] cur_rob_id;
    logic [XLEN-1:0]     res;
    logic                rob_clear;

    typedef struct {
        logic [ROB_ID_W-1:0] id;
        logic [XLEN-1:0]     val;
        int                  due;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_cnt    = 0;
    int   pulse_cnt   = 0;
    bit   rdy_q       = 1'b0;

    mdu_unit #(
        .XLEN     (XLEN),
        .ROB_ID_W (ROB_ID_W),
        .MUL_LAT  (MUL_LAT)
    ) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .mdu_input   (mdu_input),
        .op          (op),
        .r1_val      (r1_val),
        .r2_val      (r2_val),
        .inst_rob_id (inst_rob_id),
        .mul_ready   (mul_ready),
        .div_ready   (div_ready),
        .mdu_fi      (mdu_fi),
        .cur_rob_id  (cur_rob_id),
        .res         (res),
        .rob_clear   (rob_clear)
    );

    always #5 clk_in = ~clk_in;

    // Edge counter and the rdy_in value seen by the DUT at that edge.
    always @(posedge clk_in) begin
        edge_cnt <= edge_cnt + 1;
        rdy_q    <= rdy_in;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got,
                               input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d",
                     tag, got, exp, edge_cnt);
        end
    endtask

    // Reference M-extension result computed with 64-bit arithmetic.
    function automatic logic [XLEN-1:0] refModel(input logic [2:0] o,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb2;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [63:0] p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb2 = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (o)
            3'd0: begin p = sa * sb2; return p[31:0]; end
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb2; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb2; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] o,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        if (!o[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Called #1 after a clock edge; the issue is taken at the next edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b,
                                 input logic [ROB_ID_W-1:0] id,
                                 input int extra, input bit track);
        exp_t e;
        int   pos;
        op          = o;
        r1_val      = a;
        r2_val      = b;
        inst_rob_id = id;
        mdu_input   = 1'b1;
        if (track) begin
            e.id  = id;
            e.val = refModel(o, a, b);
            e.due = edge_cnt + 1 + refLatency(o, a, b) + extra;
            pos   = sb.size();
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].due > e.due) begin
                    pos = i;
                    break;
                end
            end
            sb.insert(pos, e);
        end
        @(posedge clk_in);
        #1;
        mdu_input = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
    endtask

    // Result monitor, sampled mid-cycle. Cycles following a frozen edge are
    // skipped because the output register merely holds its value then.
    always @(negedge clk_in) begin
        if (rst_n_in && rdy_q) begin
            if (mdu_fi) begin
                pulse_cnt++;
                if (sb.size() == 0) begin
                    checkOutput("spurious", 64'(mdu_fi), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("robId", 64'(cur_rob_id), 64'(e.id));
                    checkOutput("result", 64'(res), 64'(e.val));
                    checkOutput("latency", 64'(edge_cnt), 64'(e.due));
                end
            end else begin
                checkOutput("idleId", 64'(cur_rob_id), 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int p0;
        int n0;
        rst_n_in    = 1'b0;
        rdy_in      = 1'b1;
        mdu_input   = 1'b0;
        op          = '0;
        r1_val      = '0;
        r2_val      = '0;
        inst_rob_id = '0;
        rob_clear   = 1'b0;

        // Reset state
        waitCycles(3);
        checkOutput("rstFi", 64'(mdu_fi), 64'd0);
        checkOutput("rstId", 64'(cur_rob_id), 64'd0);
        checkOutput("rstRes", 64'(res), 64'd0);
        rst_n_in = 1'b1;
        waitCycles(1);
        checkOutput("rstMulRdy", 64'(mul_ready), 64'd1);
        checkOutput("rstDivRdy", 64'(div_ready), 64'd1);

        // MUL variants back to back (also exercises the pipeline)
        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'd2, 4'd1, 0, 1'b1);
        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'd2, 4'd2, 0, 1'b1);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'd2, 4'd3, 0, 1'b1);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, 4'd4, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'($urandom_range(0, 3)), $urandom, $urandom,
                          4'(5 + i), 0, 1'b1);
        end
        waitDrain(20);

        // Division values, one at a time
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd1, 0, 1'b1);
        waitDrain(50);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 4'd2, 0, 1'b1);
        waitDrain(50);
        applyStimulus(3'd5, 32'd100, 32'd7, 4'd3, 0, 1'b1);
        waitDrain(50);
        applyStimulus(3'd4, 32'h1234_5678, 32'd0, 4'd4, 0, 1'b1);
        waitDrain(10);
        applyStimulus(3'd6, 32'h1234_5678, 32'd0, 4'd5, 0, 1'b1);
        waitDrain(10);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 0, 1'b1);
        waitDrain(10);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 0, 1'b1);
        waitDrain(10);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'(4 + i), $urandom, 32'($urandom_range(1, 5000)),
                          4'(8 + i), 0, 1'b1);
            waitDrain(50);
        end

        // Conflict: MUL result lands while the divider sits in DONE
        applyStimulus(3'd4, 32'd1000, 32'd7, 4'd10, 1, 1'b1);
        waitCycles(30);
        applyStimulus(3'd0, 32'd3, 32'd4, 4'd11, 0, 1'b1);
        waitCycles(1);
        checkOutput("mulRdyDone", 64'(mul_ready), 64'd0);
        checkOutput("divRdyDone", 64'(div_ready), 64'd0);
        waitCycles(1);
        checkOutput("mulRdyDrain", 64'(mul_ready), 64'd0);
        waitDrain(10);

        // Flush with the divider busy, two MULs in flight and an issue
        // presented on the flush edge
        applyStimulus(3'd4, 32'hFFFF_FF9C, 32'd3, 4'd12, 0, 1'b0);
        applyStimulus(3'd0, 32'd5, 32'd6, 4'd13, 0, 1'b0);
        applyStimulus(3'd1, 32'd5, 32'd6, 4'd14, 0, 1'b0);
        rob_clear   = 1'b1;
        mdu_input   = 1'b1;
        op          = 3'd0;
        r1_val      = 32'd9;
        r2_val      = 32'd9;
        inst_rob_id = 4'd7;
        p0          = pulse_cnt;
        @(posedge clk_in);
        #1;
        rob_clear = 1'b0;
        mdu_input = 1'b0;
        checkOutput("fiFlush", 64'(mdu_fi), 64'd0);
        checkOutput("divRdyFlush", 64'(div_ready), 64'd1);
        waitCycles(40);
        checkOutput("flushQuiet", 64'(pulse_cnt - p0), 64'd0);
        applyStimulus(3'd5, 32'd100, 32'd7, 4'd15, 0, 1'b1);
        waitDrain(50);

        // Stall for 10 cycles in the middle of a DIV
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd3, 10, 1'b1);
        waitCycles(10);
        rdy_in = 1'b0;
        n0 = pulse_cnt;
        waitCycles(10);
        rdy_in = 1'b1;
        checkOutput("stallQuiet", 64'(pulse_cnt - n0), 64'd0);
        waitDrain(60);

        // Asynchronous reset between edges while a result is showing
        applyStimulus(3'd0, 32'd5, 32'd7, 4'd9, 0, 1'b1);
        @(posedge clk_in);
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
        checkOutput("preRstFi", 64'(mdu_fi), 64'd1);
        rst_n_in = 1'b0;
        #1;
        checkOutput("asyncFi", 64'(mdu_fi), 64'd0);
        checkOutput("asyncId", 64'(cur_rob_id), 64'd0);
        checkOutput("asyncRes", 64'(res), 64'd0);
        #1;
        rst_n_in = 1'b1;
        waitCycles(1);
        checkOutput("postRstDivRdy", 64'(div_ready), 64'd1);
        waitDrain(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
